spike_phase_detector: RTL and testbench

- Downstream consumer of two neuron spike trains (spike_a = reference oscillator, spike_b = coupled oscillator).
- Measures the period of A and the A-to-B phase offset in clock cycles, one measurement per A period.
- Asserts a lock flag once the phase offset holds steady; oscillator-network sync monitor feeding status/readout logic.

---
 rtl/spike_phase_detector.sv | 97 +++++++++
 tb/tb_spike_phase_detector.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/spike_phase_detector.sv
// spike_phase_detector: measures A period and A-to-B phase per A period, flags phase lock.
// Optional LOCK_HYST_EN: locked survives a single non-matching measurement.
module spike_phase_detector #(
    parameter int CNT_W  = 8,
    parameter int TOL    = 1,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike_a,
    input  logic             spike_b,
    output logic [CNT_W-1:0] period_a,
    output logic [CNT_W-1:0] phase_ab,
    output logic             meas_valid,
    output logic             locked,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, WAIT_B, WAIT_A} state_t;
    localparam logic [CNT_W-1:0] T_MAX = '1;
    localparam int MC_W = $clog2(LOCK_N + 1);
    state_t state, state_n;
    logic prev_a, prev_b, ev_a, ev_b, active, pub, ovf, have_ref, match, locked_n;
    logic [CNT_W-1:0] t, cap, stored, ph, diff;
    logic [MC_W-1:0] mcnt, mcnt_n;
`ifdef LOCK_HYST_EN
    logic miss;
`endif
    always_comb begin
        ev_a = spike_a & ~prev_a;
        ev_b = spike_b & ~prev_b;
        active = state != IDLE;
        pub = active && ev_a;
        ovf = active && !ev_a && t == T_MAX;
        ph = state == WAIT_B ? T_MAX : cap;
        diff = ph > stored ? ph - stored : stored - ph;
        // the very first measurement only seeds the reference
        match = have_ref && state == WAIT_A && diff <= CNT_W'(TOL);
        mcnt_n = !match ? '0 : mcnt == MC_W'(LOCK_N) ? mcnt : mcnt + 1'b1;
`ifdef LOCK_HYST_EN
        locked_n = mcnt_n == MC_W'(LOCK_N) || (locked && (match || !miss));
`else
        locked_n = mcnt_n == MC_W'(LOCK_N);
`endif
        state_n = ovf ? IDLE
                : ev_a ? (ev_b ? WAIT_A : WAIT_B)
                : (state == WAIT_B && ev_b) ? WAIT_A : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            prev_a     <= 1'b0;
            prev_b     <= 1'b0;
            t          <= '0;
            cap        <= '0;
            stored     <= '0;
            mcnt       <= '0;
            have_ref   <= 1'b0;
            period_a   <= '0;
            phase_ab   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
`ifdef LOCK_HYST_EN
            miss       <= 1'b0;
`endif
        end else begin
            prev_a     <= spike_a;
            prev_b     <= spike_b;
            state      <= state_n;
            meas_valid <= pub;
            if (ev_a) t <= CNT_W'(1);
            else if (active && t != T_MAX) t <= t + 1'b1;
            if (ev_a) cap <= '0;
            else if (state == WAIT_B && ev_b) cap <= t;
            if (ovf) begin
                overflow <= 1'b1;
                mcnt     <= '0;
                locked   <= 1'b0;
                have_ref <= 1'b0;
`ifdef LOCK_HYST_EN
                miss     <= 1'b0;
`endif
            end
            if (pub) begin
                period_a <= t;
                phase_ab <= ph;
                stored   <= ph;
                have_ref <= 1'b1;
                mcnt     <= mcnt_n;
                locked   <= locked_n;
`ifdef LOCK_HYST_EN
                miss     <= !match;
`endif
            end
        end
    end
endmodule

// File: tb/tb_spike_phase_detector.sv
// tb_spike_phase_detector: directed stimulus with a queued scoreboard checked on each meas_valid.
module tb_spike_phase_detector;
`ifdef LOCK_HYST_EN
    localparam int HYST = 1;
`else
    localparam int HYST = 0;
`endif
    logic clk = 1'b0;
    logic reset, spike_a, spike_b;
    logic [7:0] period_a, phase_ab;
    logic meas_valid, locked, overflow;
    typedef struct {int per; int ph; int lk; int ov;} exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    spike_phase_detector dut (
        .clk(clk), .reset(reset), .spike_a(spike_a), .spike_b(spike_b),
        .period_a(period_a), .phase_ab(phase_ab), .meas_valid(meas_valid),
        .locked(locked), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int per, input int ph, input int lk, input int ov);
        exp_t e;
        e.per = per; e.ph = ph; e.lk = lk; e.ov = ov;
        q.push_back(e);
    endtask

    task automatic step(input logic a, input logic b);
        spike_a = a;
        spike_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic period(input int p, input int boff);
        for (int i = 0; i < p; i++) step(i == 0, i == boff);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period_a, 0);
        chk({tag, "_phase"}, phase_ab, 0);
        chk({tag, "_valid"}, meas_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && meas_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_meas: got period %0d phase %0d expected no meas_valid", period_a, phase_ab);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("meas_period", period_a, e.per);
                chk("meas_phase", phase_ab, e.ph);
                chk("meas_locked", locked, e.lk);
                chk("meas_overflow", overflow, e.ov);
            end
        end
    end

    initial begin
        reset = 1'b1; spike_a = 1'b0; spike_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        step(0, 0);
        // steady sync: lock on the 5th measurement
        period(5, 2);
        for (int k = 1; k <= 6; k++) begin
            push(5, 2, k >= 5, 0);
            period(5, 2);
        end
        // missing B, then recovery after 5 good periods
        push(5, 2, 1, 0);
        period(5, -1);
        push(5, 255, HYST, 0);
        period(5, 2);
        for (int g = 1; g <= 5; g++) begin
            push(5, 2, g == 5, 0);
            period(5, 2);
        end
        // tolerance: 2 then 4 breaks lock, 2,3,2,3,2 regains it
        push(5, 2, 1, 0); period(5, 4);
        push(5, 4, HYST, 0); period(5, 2);
        push(5, 2, 0, 0); period(5, 3);
        push(5, 3, 0, 0); period(5, 2);
        push(5, 2, 0, 0); period(5, 3);
        push(5, 3, 0, 0); period(5, 2);
        // coincident A/B, duplicate B, held B
        push(5, 2, 1, 0); period(5, 0);
        push(5, 0, HYST, 0);
        step(1, 0); step(0, 1); step(0, 0); step(0, 1); step(0, 0);
        push(5, 1, HYST, 0);
        step(1, 0); step(0, 0); step(0, 1); step(0, 1); step(0, 1);
        // overflow: one A, then silence
        push(5, 2, HYST, 0);
        step(1, 0);
        repeat (254) step(0, 0);
        chk("pre_overflow", overflow, 0);
        chk("pre_overflow_locked", locked, HYST);
        step(0, 0);
        chk("overflow_set", overflow, 1);
        chk("overflow_locked", locked, 0);
        repeat (45) step(0, 0);
        step(1, 0);
        repeat (4) step(0, 0);
        push(5, 255, 0, 1);
        step(1, 0);
        repeat (3) step(0, 0);
        // asynchronous reset mid-run with inputs toggling
        @(posedge clk);
        #3;
        reset = 1'b1;
        spike_a = 1'b1;
        #1;
        chk_zero("async_reset");
        step(0, 1); step(1, 0); step(0, 0);
        reset = 1'b0;
        step(0, 0);
        step(1, 1);
        repeat (4) step(0, 0);
        chk("post_reset_period", period_a, 0);
        chk("post_reset_phase", phase_ab, 0);
        chk("post_reset_locked", locked, 0);
        chk("post_reset_overflow", overflow, 0);
        push(5, 0, 0, 0);
        step(1, 0);
        repeat (4) step(0, 0);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
